prefetch_slot_alloc: RTL and testbench

- Allocator and occupancy tracker for the prefetcher's outstanding-request slots.
- Holds a per-slot valid bitmap, grants the lowest free slot on request, and frees slots on completion.
- Publishes the bitmap and its population count, using onesCnt on the bitmap, so the issue stage can throttle.
- Sits between the prefetch issue logic (alloc side) and the response/retire logic (release side).

---
 rtl/prefetch_pkg.sv | 15 +
 rtl/prefetch_slot_alloc_ones_cnt.sv | 23 ++
 rtl/prefetch_slot_alloc.sv | 99 +++++++++
 tb/tb_prefetch_slot_alloc.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prefetch_pkg: shared sizing constants and types for prefetch slots   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package prefetch_pkg;

    localparam int DEF_LOG_SLOTS = 4;
    localparam int DEF_SLOTS     = 1 << DEF_LOG_SLOTS;

    typedef logic [DEF_LOG_SLOTS-1:0] slot_idx_t;
    typedef logic [DEF_LOG_SLOTS:0]   slot_cnt_t;

endpackage : prefetch_pkg
`default_nettype wire

// File: rtl/prefetch_slot_alloc_ones_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | onesCnt: population count of a 2**LOG_VEC_SIZE-bit vector            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module onesCnt
    import prefetch_pkg::*;
#(
    parameter int LOG_VEC_SIZE = DEF_LOG_SLOTS
) (
    input  logic [(1<<LOG_VEC_SIZE)-1:0] vec_i,
    output logic [LOG_VEC_SIZE:0]        cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < (1 << LOG_VEC_SIZE); i++) begin
            cnt_o = cnt_o + (LOG_VEC_SIZE+1)'(vec_i[i]);
        end
    end

endmodule : onesCnt
`default_nettype wire

// File: rtl/prefetch_slot_alloc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prefetch_slot_alloc: lowest-free slot allocator with occupancy stats |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module prefetch_slot_alloc
    import prefetch_pkg::*;
#(
    parameter int LOG_SLOTS = DEF_LOG_SLOTS,
    parameter int SLOTS     = 1 << LOG_SLOTS,
    parameter int HIGH_WM   = SLOTS - 2
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 alloc_req,
    output logic                 alloc_gnt,
    output logic [LOG_SLOTS-1:0] alloc_idx,
    input  logic                 rel_valid,
    input  logic [LOG_SLOTS-1:0] rel_idx,
    input  logic                 flush,
    output logic [0:SLOTS-1]     valid_vec,
    output logic [LOG_SLOTS:0]   occupancy,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic [LOG_SLOTS:0]   peak_occ,
    output logic                 err_rel_free
);

    localparam logic [LOG_SLOTS:0] C_FULL_CNT = (LOG_SLOTS+1)'(SLOTS);
    localparam logic [LOG_SLOTS:0] C_HIGH_WM  = (LOG_SLOTS+1)'(HIGH_WM);

    logic [0:SLOTS-1]     valid_q, valid_d;
    logic [LOG_SLOTS:0]   peak_q,  peak_d;
    logic                 err_q,   err_d;
    logic [LOG_SLOTS-1:0] w_free_idx;
    logic                 w_rel_hit;

    onesCnt #(
        .LOG_VEC_SIZE (LOG_SLOTS)
    ) u_ones_cnt (
        .vec_i (valid_q),
        .cnt_o (occupancy)
    );

    assign full        = (occupancy == C_FULL_CNT);
    assign empty       = (occupancy == '0);
    assign almost_full = (occupancy >= C_HIGH_WM);
    assign alloc_gnt   = alloc_req & ~full & ~flush & resetN;
    assign alloc_idx   = w_free_idx;
    assign valid_vec   = valid_q;
    assign peak_occ    = peak_q;
    assign err_rel_free = err_q;
    assign w_rel_hit   = valid_q[rel_idx];

    // Scan from the top down so the last write wins with the lowest free index.
    always_comb begin
        w_free_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                w_free_idx = LOG_SLOTS'(i);
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        err_d   = err_q;
        peak_d  = (occupancy > peak_q) ? occupancy : peak_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            if (alloc_gnt) begin
                valid_d[w_free_idx] = 1'b1;
            end
            if (rel_valid) begin
                if (w_rel_hit) begin
                    valid_d[rel_idx] = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            valid_q <= '0;
            peak_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            peak_q  <= peak_d;
            err_q   <= err_d;
        end
    end

endmodule : prefetch_slot_alloc
`default_nettype wire

// File: tb/tb_prefetch_slot_alloc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_prefetch_slot_alloc: directed scenarios plus randomized model run |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_prefetch_slot_alloc;

    localparam int LS = 4;
    localparam int NS = 16;
    localparam int WM = 14;

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          alloc_req = 1'b0;
    logic          alloc_gnt;
    logic [LS-1:0] alloc_idx;
    logic          rel_valid = 1'b0;
    logic [LS-1:0] rel_idx = '0;
    logic          flush = 1'b0;
    logic [0:NS-1] valid_vec;
    logic [LS:0]   occupancy;
    logic          full, empty, almost_full;
    logic [LS:0]   peak_occ;
    logic          err_rel_free;

    int n_total = 0;
    int n_pass  = 0;

    prefetch_slot_alloc #(.LOG_SLOTS(LS), .SLOTS(NS), .HIGH_WM(WM)) dut (
        .clk (clk), .resetN (resetN),
        .alloc_req (alloc_req), .alloc_gnt (alloc_gnt), .alloc_idx (alloc_idx),
        .rel_valid (rel_valid), .rel_idx (rel_idx), .flush (flush),
        .valid_vec (valid_vec), .occupancy (occupancy), .full (full),
        .empty (empty), .almost_full (almost_full), .peak_occ (peak_occ),
        .err_rel_free (err_rel_free)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req = 1'b0; rel_valid = 1'b0; flush = 1'b0; rel_idx = '0;
    endtask

    task automatic test_reset();
        idle();
        resetN = 1'b0;
        alloc_req = 1'b1;
        #3;
        n_total++; if (alloc_gnt !== 1'b0) $display("FAIL reset_gnt got=%b exp=0", alloc_gnt); else n_pass++;
        n_total++; if (valid_vec !== '0) $display("FAIL reset_vec got=%h exp=0", valid_vec); else n_pass++;
        n_total++; if (occupancy !== 0 || empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0)
            $display("FAIL reset_flags occ=%0d e=%b f=%b af=%b exp occ=0 e=1 f=0 af=0", occupancy, empty, full, almost_full);
        else n_pass++;
        n_total++; if (peak_occ !== 0 || err_rel_free !== 1'b0)
            $display("FAIL reset_regs peak=%0d err=%b exp 0/0", peak_occ, err_rel_free);
        else n_pass++;
        idle();
        tick();
        resetN = 1'b1;
        #1;
    endtask

    task automatic test_fill();
        for (int k = 0; k < NS; k++) begin
            alloc_req = 1'b1;
            #1;
            n_total++; if (alloc_gnt !== 1'b1 || alloc_idx !== LS'(k))
                $display("FAIL fill_grant k=%0d gnt=%b idx=%0d exp gnt=1 idx=%0d", k, alloc_gnt, alloc_idx, k);
            else n_pass++;
            n_total++; if (almost_full !== (k >= WM))
                $display("FAIL fill_af occ=%0d got=%b exp=%b", occupancy, almost_full, (k >= WM));
            else n_pass++;
            tick();
        end
        n_total++; if (full !== 1'b1 || occupancy !== 16)
            $display("FAIL fill_full full=%b occ=%0d exp 1/16", full, occupancy);
        else n_pass++;
        alloc_req = 1'b1;
        #1;
        n_total++; if (alloc_gnt !== 1'b0) $display("FAIL fill_17th gnt=%b exp=0", alloc_gnt); else n_pass++;
        tick();
        alloc_req = 1'b0;
        #1;
        n_total++; if (peak_occ !== 16) $display("FAIL fill_peak got=%0d exp=16", peak_occ); else n_pass++;
    endtask

    task automatic test_full_release();
        alloc_req = 1'b1; rel_valid = 1'b1; rel_idx = 4'd5;
        #1;
        n_total++; if (alloc_gnt !== 1'b0) $display("FAIL fullrel_gnt got=%b exp=0", alloc_gnt); else n_pass++;
        tick();
        rel_valid = 1'b0;
        #1;
        n_total++; if (occupancy !== 15 || alloc_idx !== 4'd5 || alloc_gnt !== 1'b1)
            $display("FAIL fullrel_next occ=%0d idx=%0d gnt=%b exp 15/5/1", occupancy, alloc_idx, alloc_gnt);
        else n_pass++;
        tick();
        alloc_req = 1'b0;
        #1;
        n_total++; if (occupancy !== 16 || full !== 1'b1)
            $display("FAIL fullrel_refill occ=%0d full=%b exp 16/1", occupancy, full);
        else n_pass++;
    endtask

    task automatic test_rel_alloc_same();
        logic [0:NS-1] exp_vec;
        flush = 1'b1; tick(); flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            alloc_req = 1'b1; tick();
        end
        alloc_req = 1'b1; rel_valid = 1'b1; rel_idx = 4'd1;
        #1;
        n_total++; if (alloc_gnt !== 1'b1 || alloc_idx !== 4'd4)
            $display("FAIL relalloc_idx gnt=%b idx=%0d exp 1/4", alloc_gnt, alloc_idx);
        else n_pass++;
        tick();
        idle();
        #1;
        exp_vec = '0;
        exp_vec[0] = 1'b1; exp_vec[2] = 1'b1; exp_vec[3] = 1'b1; exp_vec[4] = 1'b1;
        n_total++; if (valid_vec !== exp_vec || occupancy !== 4 || err_rel_free !== 1'b0)
            $display("FAIL relalloc_vec vec=%h occ=%0d err=%b exp vec=%h occ=4 err=0", valid_vec, occupancy, err_rel_free, exp_vec);
        else n_pass++;
    endtask

    task automatic test_free_release();
        logic [0:NS-1] saved;
        rel_valid = 1'b1; rel_idx = 4'd4; tick();
        rel_valid = 1'b1; rel_idx = 4'd9;
        #1;
        saved = valid_vec;
        n_total++; if (occupancy !== 3) $display("FAIL freerel_pre occ=%0d exp=3", occupancy); else n_pass++;
        tick();
        idle();
        #1;
        n_total++; if (valid_vec !== saved || err_rel_free !== 1'b1)
            $display("FAIL freerel_err vec=%h err=%b exp vec=%h err=1", valid_vec, err_rel_free, saved);
        else n_pass++;
        tick(); tick();
        n_total++; if (err_rel_free !== 1'b1) $display("FAIL freerel_sticky got=%b exp=1", err_rel_free); else n_pass++;
    endtask

    task automatic test_flush();
        for (int k = 0; k < 7; k++) begin
            alloc_req = 1'b1; tick();
        end
        alloc_req = 1'b1; flush = 1'b1;
        #1;
        n_total++; if (occupancy !== 10 || alloc_gnt !== 1'b0)
            $display("FAIL flush_gnt occ=%0d gnt=%b exp 10/0", occupancy, alloc_gnt);
        else n_pass++;
        tick();
        idle();
        #1;
        n_total++; if (valid_vec !== '0 || empty !== 1'b1 || peak_occ !== 16 || err_rel_free !== 1'b1)
            $display("FAIL flush_after vec=%h empty=%b peak=%0d err=%b exp 0/1/16/1", valid_vec, empty, peak_occ, err_rel_free);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) begin
            alloc_req = 1'b1; tick();
        end
        #2;
        resetN = 1'b0;
        #1;
        n_total++; if (valid_vec !== '0 || occupancy !== 0 || empty !== 1'b1 || peak_occ !== 0 || err_rel_free !== 1'b0 || alloc_gnt !== 1'b0)
            $display("FAIL async_reset vec=%h occ=%0d empty=%b peak=%0d err=%b gnt=%b exp all reset", valid_vec, occupancy, empty, peak_occ, err_rel_free, alloc_gnt);
        else n_pass++;
        tick();
        resetN = 1'b1;
        alloc_req = 1'b1;
        #1;
        n_total++; if (alloc_gnt !== 1'b1 || alloc_idx !== 4'd0)
            $display("FAIL async_first gnt=%b idx=%0d exp 1/0", alloc_gnt, alloc_idx);
        else n_pass++;
        alloc_req = 1'b0; flush = 1'b1; rel_valid = 1'b1; rel_idx = 4'd7;
        tick();
        idle();
        #1;
        n_total++; if (err_rel_free !== 1'b0 || valid_vec !== '0)
            $display("FAIL flush_relfree err=%b vec=%h exp 0/0", err_rel_free, valid_vec);
        else n_pass++;
    endtask

    // Reference: a set of busy slots, a running peak and a sticky error bit.
    task automatic test_random();
        bit            busy[NS];
        int            peak, cnt, exp_idx, nfail_print;
        bit            err, exp_gnt, r_req, r_rel, r_fl;
        int            r_idx;
        logic [0:NS-1] exp_vec;
        idle();
        resetN = 1'b0; #2; resetN = 1'b1; #1;
        foreach (busy[i]) busy[i] = 0;
        peak = 0; err = 0; nfail_print = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            r_req = ($urandom_range(0, 99) < 60);
            r_rel = ($urandom_range(0, 99) < 45);
            r_fl  = ($urandom_range(0, 99) < 3);
            r_idx = $urandom_range(0, NS - 1);
            alloc_req = r_req; rel_valid = r_rel; flush = r_fl; rel_idx = LS'(r_idx);
            #1;
            cnt = 0; exp_idx = 0;
            for (int i = NS - 1; i >= 0; i--) begin
                cnt += busy[i];
                if (!busy[i]) exp_idx = i;
            end
            exp_gnt = r_req && (cnt < NS) && !r_fl;
            exp_vec = '0;
            foreach (busy[i]) exp_vec[i] = busy[i];
            n_total++;
            if (alloc_gnt !== exp_gnt || (exp_gnt && alloc_idx !== LS'(exp_idx)) ||
                valid_vec !== exp_vec || occupancy !== (LS+1)'(cnt) || full !== (cnt == NS) ||
                empty !== (cnt == 0) || almost_full !== (cnt >= WM) ||
                peak_occ !== (LS+1)'(peak) || err_rel_free !== err) begin
                if (nfail_print++ < 20)
                    $display("FAIL random cyc=%0d gnt=%b idx=%0d vec=%h occ=%0d peak=%0d err=%b exp gnt=%b idx=%0d vec=%h occ=%0d peak=%0d err=%b",
                             cyc, alloc_gnt, alloc_idx, valid_vec, occupancy, peak_occ, err_rel_free,
                             exp_gnt, exp_idx, exp_vec, cnt, peak, err);
            end else n_pass++;
            tick();
            if (cnt > peak) peak = cnt;
            if (r_fl) begin
                foreach (busy[i]) busy[i] = 0;
            end else begin
                if (r_rel && !busy[r_idx]) err = 1;
                if (r_rel && busy[r_idx]) busy[r_idx] = 0;
                if (exp_gnt) busy[exp_idx] = 1;
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_release();
        test_rel_alloc_same();
        test_free_release();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_prefetch_slot_alloc
`default_nettype wire
